// File: rtl/threshold_unit.sv
// Double-threshold edge classifier: streams one gradient-magnitude frame from the
// suppression buffer and writes a none/weak/strong class for every pixel.
module threshold_unit #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              threshold_enable,
    output logic              threshold_done,
    input  logic [PIX_W-1:0]  high_thresh,
    input  logic [PIX_W-1:0]  low_thresh,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        wr_data,
    output logic [ADDR_W:0]   strong_count,
    output logic [ADDR_W:0]   weak_count,
    output logic [1:0]        dbg_state_o
);
    localparam int N = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [1:0] CLS_NONE   = 2'b00;
    localparam logic [1:0] CLS_WEAK   = 2'b01;
    localparam logic [1:0] CLS_STRONG = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [PIX_W-1:0]  hi_q;
    logic [PIX_W-1:0]  lo_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_pend_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic              drain_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [1:0]        wr_data_q;
    logic              done_q;
    logic [ADDR_W:0]   strong_cnt_q;
    logic [ADDR_W:0]   weak_cnt_q;
    logic [ADDR_W:0]   strong_count_q;
    logic [ADDR_W:0]   weak_count_q;
    logic [PIX_W-1:0]  eff_lo_d;
    logic [1:0]        cls_d;

    // A low threshold above the high one collapses the weak band to nothing.
    always_comb begin
        eff_lo_d = (low_thresh < high_thresh) ? low_thresh : high_thresh;
        cls_d    = CLS_NONE;
        if (rd_data >= hi_q) begin
            cls_d = CLS_STRONG;
        end else if (rd_data >= lo_q) begin
            cls_d = CLS_WEAK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            hi_q           <= '0;
            lo_q           <= '0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            rd_pend_q      <= 1'b0;
            pend_addr_q    <= '0;
            drain_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= CLS_NONE;
            done_q         <= 1'b0;
            strong_cnt_q   <= '0;
            weak_cnt_q     <= '0;
            strong_count_q <= '0;
            weak_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rd_en_q   <= 1'b0;
                    rd_pend_q <= 1'b0;
                    wr_en_q   <= 1'b0;
                    done_q    <= 1'b0;
                    if (threshold_enable) begin
                        state_q      <= RUN;
                        hi_q         <= high_thresh;
                        lo_q         <= eff_lo_d;
                        strong_cnt_q <= '0;
                        weak_cnt_q   <= '0;
                        rd_en_q      <= 1'b1;
                        rd_addr_q    <= '0;
                    end
                end
                RUN, DRAIN: begin
                    if (!threshold_enable) begin
                        // Abort: drop the read/write pipeline, keep the last published counts.
                        state_q   <= IDLE;
                        rd_en_q   <= 1'b0;
                        rd_pend_q <= 1'b0;
                        wr_en_q   <= 1'b0;
                    end else begin
                        rd_pend_q   <= rd_en_q;
                        pend_addr_q <= rd_addr_q;
                        wr_en_q     <= rd_pend_q;
                        if (rd_pend_q) begin
                            wr_addr_q    <= pend_addr_q;
                            wr_data_q    <= cls_d;
                            strong_cnt_q <= strong_cnt_q + (ADDR_W+1)'(cls_d == CLS_STRONG);
                            weak_cnt_q   <= weak_cnt_q + (ADDR_W+1)'(cls_d == CLS_WEAK);
                        end
                        if (state_q == RUN) begin
                            if (rd_addr_q == LAST_ADDR) begin
                                state_q <= DRAIN;
                                rd_en_q <= 1'b0;
                                drain_q <= 1'b0;
                            end else begin
                                rd_addr_q <= rd_addr_q + ADDR_W'(1);
                            end
                        end else if (drain_q) begin
                            state_q        <= DONE;
                            done_q         <= 1'b1;
                            strong_count_q <= strong_cnt_q;
                            weak_count_q   <= weak_cnt_q;
                        end else begin
                            drain_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    if (!threshold_enable) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign threshold_done = done_q;
    assign rd_en          = rd_en_q;
    assign rd_addr        = rd_addr_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign strong_count   = strong_count_q;
    assign weak_count     = weak_count_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_threshold_unit.sv
// Bench for threshold_unit on a 4x4 frame: directed scenarios plus random frames
// checked against a per-pixel classification model and the documented write timing.
module tb_threshold_unit;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 4;
    localparam int N      = IMG_W * IMG_H;
    localparam int W      = ADDR_W + 2;

    // Handshake: rd_en/rd_addr request a pixel, rd_data answers exactly one cycle
    // later; wr_en marks a single-cycle write of wr_data to wr_addr.
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              threshold_enable = 1'b0;
    logic              threshold_done;
    logic [PIX_W-1:0]  high_thresh = '0;
    logic [PIX_W-1:0]  low_thresh = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_data;
    logic [ADDR_W:0]   strong_count;
    logic [ADDR_W:0]   weak_count;
    logic [1:0]        dbg_state_o;

    logic [PIX_W-1:0]  mem [N];
    logic [W-1:0]      exp_q[$];
    int                n_total = 0;
    int                n_bad = 0;
    int                last_strong = 0;
    int                last_weak = 0;

    threshold_unit #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .threshold_enable(threshold_enable),
        .threshold_done(threshold_done), .high_thresh(high_thresh),
        .low_thresh(low_thresh), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .strong_count(strong_count), .weak_count(weak_count),
        .dbg_state_o(dbg_state_o)
    );

    // Clock and suppression-buffer model.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_class(input logic [7:0] p, input logic [7:0] hi,
                                             input logic [7:0] lo);
        logic [7:0] lo_eff;
        lo_eff = (lo < hi) ? lo : hi;
        if (p >= hi) return 2'b10;
        if (p >= lo_eff) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_done"}, 32'(threshold_done), 0);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_strong"}, 32'(strong_count), 0);
        check({tag, "_weak"}, 32'(weak_count), 0);
        check({tag, "_state"}, 32'(dbg_state_o), 0);
    endtask

    // One frame: abort_at / rst_at / chg_at are RUN-relative cycle numbers (-1 = unused).
    task automatic run_frame(input logic [7:0] hi, input logic [7:0] lo,
                             input int abort_at, input int rst_at, input int chg_at);
        int         cyc;
        int         rd_cnt;
        int         max_wr;
        int         last_k;
        int         ms;
        int         mw;
        bit         done_seen;
        bit         stop;
        logic [W-1:0] e;
        last_k = N - 1;
        if (abort_at >= 0) last_k = (abort_at - 2 < N - 1) ? abort_at - 2 : N - 1;
        exp_q.delete();
        ms = 0;
        mw = 0;
        for (int k = 0; k < N; k++) begin
            logic [1:0] c;
            c = ref_class(mem[k], hi, lo);
            if (c == 2'b10) ms++;
            if (c == 2'b01) mw++;
            if (k <= last_k) exp_q.push_back({ADDR_W'(k), c});
        end

        @(negedge clk);
        threshold_enable = 1'b1;
        high_thresh = hi;
        low_thresh = lo;
        cyc = 0;
        rd_cnt = 0;
        max_wr = -1;
        done_seen = 0;
        stop = 0;
        while (!stop && cyc < 4 * N) begin
            @(negedge clk);
            if (rd_en) begin
                rd_cnt++;
                check("rd_addr", 32'(rd_addr), cyc);
            end
            if (wr_en) begin
                if (int'(wr_addr) > max_wr) max_wr = int'(wr_addr);
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 32'(wr_en), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e[W-1:2]));
                    check("wr_data", 32'(wr_data), 32'(e[1:0]));
                    check("wr_cycle", cyc, 32'(e[W-1:2]) + 2);
                end
            end
            if (threshold_done) begin
                done_seen = 1;
                stop = 1;
                check("done_cycle", cyc, N + 2);
            end
            if (cyc == chg_at) begin
                high_thresh = '0;
                low_thresh = '0;
            end
            if (cyc == abort_at) begin
                threshold_enable = 1'b0;
                stop = 1;
            end
            if (cyc == rst_at) begin
                reset = 1'b1;
                stop = 1;
            end
            cyc++;
        end

        if (rst_at >= 0) begin
            @(negedge clk);
            check_idle_zero("mid_reset");
            reset = 1'b0;
            threshold_enable = 1'b0;
            exp_q.delete();
            last_strong = 0;
            last_weak = 0;
        end else if (abort_at >= 0) begin
            check("abort_no_done", 32'(done_seen), 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("abort_rd_en", 32'(rd_en), 0);
                check("abort_wr_en", 32'(wr_en), 0);
                check("abort_done", 32'(threshold_done), 0);
                if (i == 0) check("abort_state", 32'(dbg_state_o), 0);
            end
            check("abort_max_wr", max_wr, last_k);
            check("abort_missing", exp_q.size(), 0);
            check("abort_strong", 32'(strong_count), last_strong);
            check("abort_weak", 32'(weak_count), last_weak);
        end else begin
            if (!done_seen) check("done_timeout", 32'(threshold_done), 1);
            check("rd_count", rd_cnt, N);
            check("wr_missing", exp_q.size(), 0);
            check("strong_count", 32'(strong_count), ms);
            check("weak_count", 32'(weak_count), mw);
            check("done_rd_en", 32'(rd_en), 0);
            check("done_wr_en", 32'(wr_en), 0);
            @(negedge clk);
            check("done_hold", 32'(threshold_done), 1);
            check("done_state", 32'(dbg_state_o), 3);
            threshold_enable = 1'b0;
            @(negedge clk);
            check("done_clear", 32'(threshold_done), 0);
            check("idle_state", 32'(dbg_state_o), 0);
            check("strong_held", 32'(strong_count), ms);
            check("weak_held", 32'(weak_count), mw);
            last_strong = ms;
            last_weak = mw;
        end
    endtask

    initial begin
        logic [7:0] hi;
        logic [7:0] lo;
        for (int k = 0; k < N; k++) mem[k] = 8'(16 * k);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;

        // Abort at RUN cycle 5 straight after reset.
        run_frame(8'd200, 8'd100, 5, -1, -1);

        // Ramp frame, basic classification and done latency.
        run_frame(8'd200, 8'd100, -1, -1, -1);
        check("ramp_strong", 32'(strong_count), 3);
        check("ramp_weak", 32'(weak_count), 6);

        // Thresholds zeroed mid-frame must not matter.
        run_frame(8'd200, 8'd100, -1, -1, 2);
        check("chg_strong", 32'(strong_count), 3);
        check("chg_weak", 32'(weak_count), 6);

        // Low above high: no weak band.
        run_frame(8'd50, 8'd120, -1, -1, -1);
        check("inv_strong", 32'(strong_count), 12);
        check("inv_weak", 32'(weak_count), 0);

        // Reset during the first DRAIN cycle, then a clean frame.
        run_frame(8'd200, 8'd100, -1, N, -1);
        run_frame(8'd200, 8'd100, -1, -1, -1);
        check("rerun_strong", 32'(strong_count), 3);
        check("rerun_weak", 32'(weak_count), 6);

        // Saturated pixels equal to both thresholds.
        for (int k = 0; k < N; k++) mem[k] = 8'd255;
        run_frame(8'd255, 8'd255, -1, -1, -1);
        check("sat_strong", 32'(strong_count), 16);
        check("sat_weak", 32'(weak_count), 0);

        // Random frames, with threshold-boundary pixels planted on even rounds.
        for (int r = 0; r < 8; r++) begin
            hi = 8'($urandom_range(0, 255));
            lo = 8'($urandom_range(0, 255));
            for (int k = 0; k < N; k++) mem[k] = 8'($urandom_range(0, 255));
            if (r % 2 == 0) begin
                mem[0] = hi;
                mem[1] = lo;
                mem[2] = hi - 8'd1;
                mem[3] = lo - 8'd1;
            end
            if (r == 3) run_frame(hi, lo, $urandom_range(2, N + 1), -1, -1);
            else run_frame(hi, lo, -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/threshold_unit.md
THRESHOLD_UNIT -- requirements
Module: threshold_unit

Interface
REQ-001 Parameter IMG_W, default 64, image width in pixels.
REQ-002 Parameter IMG_H, default 64, image height in pixels; N = IMG_W*IMG_H.
REQ-003 Parameter PIX_W, default 8, gradient-magnitude pixel width.
REQ-004 Parameter ADDR_W, default 12, buffer address width; SHALL satisfy 2^ADDR_W >= N.
REQ-005 clk  input  1  rising-edge clock, sole clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 threshold_enable  input  1  level enable from control unit; high = run stage.
REQ-008 threshold_done  output  1  level; high while stage complete and enable still high.
REQ-009 high_thresh  input  PIX_W  strong threshold, sampled at start.
REQ-010 low_thresh  input  PIX_W  weak threshold, sampled at start.
REQ-011 rd_en  output  1  suppression-buffer read strobe.
REQ-012 rd_addr  output  ADDR_W  suppression-buffer read address.
REQ-013 rd_data  input  PIX_W  read data; valid exactly 1 cycle after rd_en.
REQ-014 wr_en  output  1  edge-class buffer write strobe.
REQ-015 wr_addr  output  ADDR_W  edge-class buffer write address.
REQ-016 wr_data  output  2  class: 2'b00 none, 2'b01 weak, 2'b10 strong; 2'b11 never emitted.
REQ-017 strong_count  output  ADDR_W+1  strong pixels in last completed frame.
REQ-018 weak_count  output  ADDR_W+1  weak pixels in last completed frame.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; all outputs registered.
REQ-020 IDLE: threshold_enable=1 -> RUN next cycle; latch high_thresh, low_thresh; clear internal counters.
REQ-021 Effective low = min(low_thresh, high_thresh) (low>high -> no weak pixels).
REQ-022 RUN cycle k (k=0..N-1): rd_en=1, rd_addr=k; after k=N-1 -> DRAIN.
REQ-023 Classification of pixel k: rd_data >= high -> strong; else >= effective low -> weak; else none; unsigned compare.
REQ-024 Pixel k written at cycle k+2: wr_en=1, wr_addr=k, wr_data=class; exactly one write per pixel, ascending, no gaps.
REQ-025 DRAIN lasts 2 cycles (last write at cycle N+1) -> DONE at cycle N+2.
REQ-026 DONE: threshold_done=1; strong_count/weak_count updated on DONE entry and held until next DONE entry.
REQ-027 DONE: threshold_enable=0 -> IDLE next cycle, threshold_done=0 in IDLE.
REQ-028 threshold_enable=0 in RUN/DRAIN -> abort: IDLE next cycle, rd_en/wr_en forced 0 that cycle onward, in-flight writes discarded, counts unchanged, no done.
REQ-029 Threshold input changes after start SHALL NOT affect current frame.
REQ-030 rd_en=0 and wr_en=0 in IDLE and DONE; rd_en=0 in DRAIN.
REQ-031 Internal counters saturate-free: max count N fits ADDR_W+1 bits.

Reset
REQ-032 reset=1 at clock edge -> IDLE; threshold_done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0; strong_count, weak_count = 0.
REQ-033 Reset overrides all other inputs, including mid-RUN; no write issued in cycle after reset.

Verification (IMG_W=4, IMG_H=4, PIX_W=8, ADDR_W=4)
REQ-034 Pixels 0..15 = 16*k, high=200, low=100, enable held -> class 00 for k<=6, 01 for k=7..12, 10 for k=13..15; strong_count=3, weak_count=6; done first high 18 cycles after first rd_en.
REQ-035 high=50, low=120, same pixels -> weak_count=0, strong_count=12, no 2'b01 written.
REQ-036 Enable dropped at RUN cycle 5 -> IDLE next cycle, max wr_addr written = 3, no done, counts stay 0 after reset.
REQ-037 reset=1 during DRAIN -> next cycle all outputs 0, state IDLE; re-enable -> full 16-write frame with correct classes.
REQ-038 All pixels = 255, high=255, low=255 -> all class 10, strong_count=16; enable low in DONE -> done=0 next cycle.
REQ-039 Thresholds changed to 0 at RUN cycle 2 of REQ-034 stimulus -> results identical to REQ-034.
